// File: rtl/uart_rx_deserializer.sv
// UART receive front end: line sync, start qualification, mid-bit sampling
// and a one-entry valid/ready holding register with error status.
module uart_rx_deserializer #(
    parameter int RX_OVERSAMPLE = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_Rx_ClkTick,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Ready,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Rx_Valid,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Overrun
);

    localparam int CW = $clog2(RX_OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(RX_OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [BW-1:0]        bit_cnt, bit_nx;
    logic                 stop_idx, stop_nx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_r, frm_err_r;
    logic                 tick_prev, rx_meta, rx_s;
    logic                 tick_en, at_end;
    logic                 shift_en, par_en, stop_en, done;
    logic                 par_calc, par_bad, frm_fin;

    assign tick_en  = i_Rx_ClkTick & ~tick_prev;
    assign at_end   = (cnt == CNT_END);
    assign par_calc = (^shreg) ^ rx_s;
    assign par_bad  = (PARITY == 1) ? ~par_calc : par_calc;
    assign frm_fin  = frm_err_r | ~rx_s;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_cnt;
        stop_nx  = stop_idx;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        done     = 1'b0;
        if (tick_en) begin
            unique case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_nx = S_START;
                        cnt_nx   = '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt_nx   = '0;
                        bit_nx   = '0;
                        state_nx = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (at_end) begin
                        shift_en = 1'b1;
                        cnt_nx   = '0;
                        bit_nx   = bit_cnt + 1'b1;
                        stop_nx  = 1'b0;
                        if (bit_cnt == BIT_LAST)
                            state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (at_end) begin
                        par_en   = 1'b1;
                        cnt_nx   = '0;
                        state_nx = S_STOP;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (at_end) begin
                        stop_en = 1'b1;
                        cnt_nx  = '0;
                        if (STOP_BITS == 2 && !stop_idx) begin
                            stop_nx = 1'b1;
                        end else begin
                            done     = 1'b1;
                            state_nx = rx_s ? S_IDLE : S_BREAK;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_prev    <= 1'b1;
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_err_r    <= 1'b0;
            frm_err_r    <= 1'b0;
            o_Rx_Data    <= '0;
            o_Rx_Valid   <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            tick_prev <= i_Rx_ClkTick;
            rx_meta   <= i_Rx_Serial;
            rx_s      <= rx_meta;
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_cnt   <= bit_nx;
            stop_idx  <= stop_nx;
            // per-character error accumulators restart with each start edge
            if (tick_en && state == S_IDLE) begin
                par_err_r <= 1'b0;
                frm_err_r <= 1'b0;
            end
            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (par_en) par_err_r <= par_bad;
            if (stop_en) frm_err_r <= frm_fin;
            if (done) begin
                if (!o_Rx_Valid || i_Rx_Ready) begin
                    o_Rx_Data    <= shreg;
                    o_Frame_Err  <= frm_fin;
                    o_Parity_Err <= par_err_r;
                    o_Rx_Valid   <= 1'b1;
                end else begin
                    o_Overrun <= 1'b1;
                end
            end else if (o_Rx_Valid && i_Rx_Ready) begin
                o_Rx_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench: default-format receiver plus an even-parity receiver.
module tb_uart_rx_deserializer;

    localparam int BIT_CLK = 192;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       ser0 = 1'b1, rdy0 = 1'b1;
    logic       ser1 = 1'b1, rdy1 = 1'b1;
    logic [7:0] d0, d1;
    logic       v0, fe0, pe0, ov0;
    logic       v1, fe1, pe1, ov1;
    int         checks = 0;
    int         errors = 0;
    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       m0, m1;

    uart_rx_deserializer dut0 (
        .clk(clk), .reset(reset), .i_Rx_ClkTick(tick),
        .i_Rx_Serial(ser0), .i_Rx_Ready(rdy0),
        .o_Rx_Data(d0), .o_Rx_Valid(v0), .o_Frame_Err(fe0),
        .o_Parity_Err(pe0), .o_Overrun(ov0)
    );

    uart_rx_deserializer #(.PARITY(2)) dut1 (
        .clk(clk), .reset(reset), .i_Rx_ClkTick(tick),
        .i_Rx_Serial(ser1), .i_Rx_Ready(rdy1),
        .o_Rx_Data(d1), .o_Rx_Valid(v1), .o_Frame_Err(fe1),
        .o_Parity_Err(pe1), .o_Overrun(ov1)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (6) @(posedge clk);
        #1 tick = ~tick;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && v0 && rdy0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected: got %0h expected none", d0);
            end else begin
                m0 = q0.pop_front();
                chk("dut0_data", 32'(d0), 32'(m0.d));
                chk("dut0_ferr", 32'(fe0), 32'(m0.fe));
                chk("dut0_perr", 32'(pe0), 32'(m0.pe));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && v1 && rdy1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected: got %0h expected none", d1);
            end else begin
                m1 = q1.pop_front();
                chk("dut1_data", 32'(d1), 32'(m1.d));
                chk("dut1_ferr", 32'(fe1), 32'(m1.fe));
                chk("dut1_perr", 32'(pe1), 32'(m1.pe));
            end
        end
    end

    // bits are sent LSB first, one bit time each
    task automatic send_bits(input int which, input logic [15:0] bits,
                             input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) ser0 = bits[i];
            else ser1 = bits[i];
            wclk(BIT_CLK);
        end
    endtask

    task automatic send0(input logic [7:0] data, input logic stopb,
                         input bit push);
        exp_t e;
        e.d  = data;
        e.fe = ~stopb;
        e.pe = 1'b0;
        if (push) q0.push_back(e);
        send_bits(0, {6'b0, stopb, data, 1'b0}, 10);
    endtask

    task automatic send1(input logic [7:0] data, input logic pbit);
        exp_t e;
        e.d  = data;
        e.fe = 1'b0;
        e.pe = ((($countones(data) + int'(pbit)) % 2) != 0);
        q1.push_back(e);
        send_bits(1, {5'b0, 1'b1, pbit, data, 1'b0}, 11);
    endtask

    initial begin
        wclk(4);
        chk("rst_data", 32'(d0), 0);
        chk("rst_valid", 32'(v0), 0);
        chk("rst_ferr", 32'(fe0), 0);
        chk("rst_perr", 32'(pe0), 0);
        chk("rst_ovr", 32'(ov0), 0);
        reset = 1'b0;
        wclk(400);

        send0(8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send0(8'($urandom), 1'b1, 1'b1);

        for (int k = 0; k < 3; k++) begin
            wclk($urandom_range(0, 11));
            ser0 = 1'b0;
            wclk(4);
            ser0 = 1'b1;
            wclk(2 * BIT_CLK);
            chk("glitch_valid", 32'(v0), 0);
        end

        send1(8'h3C, 1'b0);
        send1(8'h3C, 1'b1);
        for (int i = 0; i < 4; i++)
            send1(8'($urandom), 1'($urandom));

        send0(8'h55, 1'b0, 1'b1);
        ser0 = 1'b0;
        wclk(3 * BIT_CLK);
        ser0 = 1'b1;
        wclk(2 * BIT_CLK);
        chk("brk_valid", 32'(v0), 0);

        rdy0 = 1'b0;
        send0(8'h11, 1'b1, 1'b1);
        send0(8'h22, 1'b1, 1'b0);
        chk("ovr_valid", 32'(v0), 1);
        chk("ovr_data", 32'(d0), 32'h11);
        chk("ovr_flag", 32'(ov0), 1);
        rdy0 = 1'b1;
        wclk(1);
        chk("ovr_consumed", 32'(v0), 0);
        chk("ovr_sticky", 32'(ov0), 1);
        wclk(BIT_CLK);

        ser0 = 1'b0;
        wclk(5 * BIT_CLK);
        ser0 = 1'b1;
        wclk(BIT_CLK / 2);
        reset = 1'b1;
        wclk(1);
        chk("mid_rst_data", 32'(d0), 0);
        chk("mid_rst_valid", 32'(v0), 0);
        chk("mid_rst_ferr", 32'(fe0), 0);
        chk("mid_rst_perr", 32'(pe0), 0);
        chk("mid_rst_ovr", 32'(ov0), 0);
        chk("mid_rst_data1", 32'(d1), 0);
        wclk(3);
        reset = 1'b0;
        wclk(4 * BIT_CLK);
        send0(8'h0F, 1'b1, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            wclk(1);
        end
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("final_ovr", 32'(ov0), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
